// File: rtl/scope_pkg.sv
// Shared types for the scope capture path: ADC sample width, capture
// FSM state encoding and the edge-trigger compare.
package scope_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Threshold crossing between two consecutive samples (unsigned, no hysteresis).
  function automatic logic edge_hit(input logic             rise,
                                    input logic [ADC_W-1:0] prev,
                                    input logic [ADC_W-1:0] cur,
                                    input logic [ADC_W-1:0] level);
    if (rise) edge_hit = (prev < level) && (cur >= level);
    else      edge_hit = (prev > level) && (cur <= level);
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running divider: produces the ADC conversion clock and a one-cycle
// sample strobe in the cycle after the last divider phase.
module adc_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic adc_clk_o,
  output logic samp_pre_o,   // last divider phase: sample edge ends this cycle
  output logic samp_stb_o    // high for one cycle after the sample edge
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             adc_clk_q, samp_stb_q;

  assign samp_pre_o = (div_cnt_q == LAST);
  assign div_cnt_d  = samp_pre_o ? '0 : div_cnt_q + 1'b1;

  // Counter wraps at CLK_DIV-1; clock and strobe are registered off the count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      samp_stb_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= (div_cnt_q < HALF);
      samp_stb_q <= samp_pre_o;
    end
  end

  assign adc_clk_o  = adc_clk_q;
  assign samp_stb_o = samp_stb_q;

endmodule

// File: rtl/adc_in_capture.sv
// ADC input capture: registers ADC samples, detects a threshold crossing
// (or forced trigger) and writes DEPTH consecutive samples, starting with
// the trigger sample, into the scope sample RAM.
module adc_in_capture
  import scope_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  output logic              adc_clk,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_force,
  input  logic              trig_rise,
  input  logic [ADC_W-1:0]  trig_level,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADC_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output cap_state_e        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic              TRIG_LAST = (DEPTH == 1);

  logic             samp_pre, samp_stb;
  logic [ADC_W-1:0] adc_q, prev_q;
  logic             prev_valid_q;
  cap_state_e       state_q;
  logic             wr_en_q, busy_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, addr_nx;
  logic [ADC_W-1:0] wr_data_q;
  logic             trig;

  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .adc_clk_o  (adc_clk),
    .samp_pre_o (samp_pre),
    .samp_stb_o (samp_stb)
  );

  // Sample register: latch on the last divider phase, keep the previous sample for edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_q  <= '0;
      prev_q <= '0;
    end else begin
      if (samp_pre) adc_q  <= adc_data;
      if (samp_stb) prev_q <= adc_q;
    end
  end

  assign trig    = samp_stb &&
                   (trig_force || (prev_valid_q && edge_hit(trig_rise, prev_q, adc_q, trig_level)));
  assign addr_nx = wr_addr_q + 1'b1;

  // Write port: wr_en is a push-only strobe (no ready); wr_addr/wr_data are
  // valid exactly in the cycle wr_en is high and the RAM must accept every write.
  // Capture FSM with registered busy/done and write port; abort has priority over arm.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm) begin
              state_q      <= ST_ARMED;
              prev_valid_q <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (samp_stb) prev_valid_q <= 1'b1;
            if (trig) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= adc_q;
              if (TRIG_LAST) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (samp_stb) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_nx;
              wr_data_q <= adc_q;
              if (addr_nx == LAST_ADDR) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (arm) begin
              state_q      <= ST_ARMED;
              prev_valid_q <= 1'b0;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_in_capture.sv
// Bench for adc_in_capture: drives an ADC sample stream (one sample per
// adc_clk period, changing on the adc_clk rising edge), collects RAM writes
// and compares them with a sample-list model of the trigger rules.
module tb_adc_in_capture;
  import scope_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;

  logic              sys_clk, rst_n, adc_clk;
  logic [7:0]        adc_data, trig_level, wr_data;
  logic              arm, abort, trig_force, trig_rise, wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  cap_state_e        dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drive_cyc;

  logic [ADDR_W-1:0] got_addr_q[$];
  logic [7:0]        got_data_q[$];
  int                got_cyc_q[$];
  logic [7:0]        exp_q[$];
  logic [7:0]        stim[$];

  adc_in_capture #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .adc_clk    (adc_clk),
    .adc_data   (adc_data),
    .arm        (arm),
    .abort      (abort),
    .trig_force (trig_force),
    .trig_rise  (trig_rise),
    .trig_level (trig_level),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Write collector, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      got_addr_q.push_back(wr_addr);
      got_data_q.push_back(wr_data);
      got_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  // Index of the trigger sample in a stream whose element 0 is the sample
  // presented in the period arm was issued; -1 if none.
  function automatic int find_trig(input logic [7:0] s[$], input bit rise,
                                   input bit frc, input logic [7:0] lvl);
    for (int i = 0; i < s.size(); i++) begin
      if (frc) return i;
      if (i > 0) begin
        if (rise && s[i-1] < lvl && s[i] >= lvl) return i;
        if (!rise && s[i-1] > lvl && s[i] <= lvl) return i;
      end
    end
    return -1;
  endfunction

  function automatic void build_exp(input int t);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++)
      if (t >= 0 && t + i < stim.size()) exp_q.push_back(stim[t + i]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic clear_got();
    got_addr_q.delete();
    got_data_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic wait_adc_rise();
    logic last_clk;
    last_clk = adc_clk;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(posedge sys_clk); #1;
      if (adc_clk === 1'b1 && last_clk === 1'b0) return;
      last_clk = adc_clk;
    end
    total++; bad++;
    $display("FAIL adc_clk_rise: no rising edge within %0d cycles, required one", 3 * CLK_DIV);
    finish_run();
  endtask

  task automatic present(input logic [7:0] v, input logic a);
    wait_adc_rise();
    adc_data  = v;
    arm       = a;
    drive_cyc = cyc;
    @(posedge sys_clk); #1;
    arm = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < (n + 4) * CLK_DIV; i++) begin
      if (got_data_q.size() >= n) return;
      @(posedge sys_clk); #1;
    end
    total++; bad++;
    $display("FAIL wait_writes: got %0d writes, required %0d", got_data_q.size(), n);
    finish_run();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge sys_clk); #1;
    total++; if (adc_clk !== 1'b0) begin bad++; $display("FAIL rst_adc_clk: got %b want 0", adc_clk); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    total++; if (wr_addr !== '0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_clocking();
    int n_err, n_wr;
    n_err = 0; n_wr = 0;
    wait_adc_rise();
    for (int k = 1; k < 4 * CLK_DIV; k++) begin
      @(posedge sys_clk); #1;
      if (adc_clk !== ((k % CLK_DIV) < CLK_DIV / 2)) n_err++;
      if (wr_en !== 1'b0) n_wr++;
    end
    total++; if (n_err != 0) begin bad++; $display("FAIL clk_pattern: %0d cycles off, want 0", n_err); end
    total++; if (n_wr != 0) begin bad++; $display("FAIL clk_no_write: %0d write cycles, want 0", n_wr); end
  endtask

  task automatic test_rising();
    int n_pre, t, n_err, n_sp;
    trig_rise = 1'b1; trig_level = 8'h80; trig_force = 1'b0;
    stim.delete();
    n_pre = $urandom_range(2, 6);
    for (int i = 0; i < n_pre; i++) stim.push_back(8'($urandom_range(0, 8'h6F)));
    stim.push_back(8'h70); stim.push_back(8'h78); stim.push_back(8'h80);
    for (int i = 0; i < DEPTH + 3; i++) stim.push_back(8'($urandom));
    t = find_trig(stim, 1'b1, 1'b0, 8'h80);
    build_exp(t);
    clear_got();
    for (int i = 0; i < stim.size(); i++) begin
      present(stim[i], (i == 0) || (i == t + 200));  // the second arm lands mid-capture
      if (i == t - 1) begin
        total++;
        if (busy !== 1'b1 || got_data_q.size() != 0) begin
          bad++; $display("FAIL rise_armed: busy=%b writes=%0d, want busy=1 writes=0", busy, got_data_q.size());
        end
      end
    end
    total++; if (got_data_q.size() != DEPTH) begin bad++; $display("FAIL rise_count: got %0d want %0d", got_data_q.size(), DEPTH); end
    if (got_data_q.size() > 0) begin
      total++;
      if (got_addr_q[0] !== '0 || got_data_q[0] !== 8'h80) begin
        bad++; $display("FAIL rise_first: addr=%0d data=%h, want addr=0 data=80", got_addr_q[0], got_data_q[0]);
      end
    end
    n_err = 0; n_sp = 0;
    for (int i = 0; i < got_data_q.size() && i < exp_q.size(); i++) begin
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) n_err++;
      if (i > 0 && got_cyc_q[i] - got_cyc_q[i-1] != CLK_DIV) n_sp++;
    end
    total++; if (n_err != 0) begin bad++; $display("FAIL rise_stream: %0d wrong writes, want 0", n_err); end
    total++; if (n_sp != 0) begin bad++; $display("FAIL rise_spacing: %0d gaps not %0d cycles, want 0", n_sp, CLK_DIV); end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rise_done: done=%b busy=%b, want 1 0", done, busy); end
  endtask

  task automatic test_falling();
    int t, n_err;
    trig_rise = 1'b0; trig_level = 8'h40; trig_force = 1'b0;
    stim.delete();
    for (int i = 0; i < 21; i++) stim.push_back(8'h40);
    stim.push_back(8'h50); stim.push_back(8'h48); stim.push_back(8'h40);
    for (int i = 0; i < DEPTH + 3; i++) stim.push_back(8'($urandom));
    t = find_trig(stim, 1'b0, 1'b0, 8'h40);
    build_exp(t);
    clear_got();
    for (int i = 0; i < stim.size(); i++) begin
      present(stim[i], i == 0);  // rearm from DONE
      if (i == 20) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || got_data_q.size() != 0) begin
          bad++; $display("FAIL fall_flat: busy=%b done=%b writes=%0d, want 1 0 0", busy, done, got_data_q.size());
        end
      end
    end
    total++; if (got_data_q.size() != DEPTH) begin bad++; $display("FAIL fall_count: got %0d want %0d", got_data_q.size(), DEPTH); end
    if (got_data_q.size() > 0) begin
      total++;
      if (got_addr_q[0] !== '0 || got_data_q[0] !== 8'h40) begin
        bad++; $display("FAIL fall_first: addr=%0d data=%h, want addr=0 data=40", got_addr_q[0], got_data_q[0]);
      end
    end
    n_err = 0;
    for (int i = 0; i < got_data_q.size() && i < exp_q.size(); i++)
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) n_err++;
    total++; if (n_err != 0) begin bad++; $display("FAIL fall_stream: %0d wrong writes, want 0", n_err); end
  endtask

  task automatic test_force();
    int arm_cyc, n_err;
    trig_force = 1'b1; trig_rise = 1'b1; trig_level = 8'hFF;
    clear_got();
    for (int i = 0; i < DEPTH + 3; i++) begin
      present(8'h33, i == 0);
      if (i == 0) arm_cyc = drive_cyc;
    end
    total++; if (got_data_q.size() != DEPTH) begin bad++; $display("FAIL force_count: got %0d want %0d", got_data_q.size(), DEPTH); end
    if (got_data_q.size() > 0) begin
      total++;
      if (got_cyc_q[0] != arm_cyc + CLK_DIV) begin
        bad++; $display("FAIL force_latency: first write at cycle %0d, want %0d", got_cyc_q[0], arm_cyc + CLK_DIV);
      end
    end
    n_err = 0;
    for (int i = 0; i < got_data_q.size(); i++)
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== 8'h33) n_err++;
    total++; if (n_err != 0) begin bad++; $display("FAIL force_stream: %0d wrong writes, want 0", n_err); end
    total++; if (dbg_state !== ST_DONE || done !== 1'b1) begin bad++; $display("FAIL force_done: state=%0d done=%b, want DONE 1", dbg_state, done); end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    trig_force = 1'b1;
    v = 8'($urandom);
    clear_got();
    present(v, 1'b1);
    wait_writes(100);
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL abort_idle: busy=%b done=%b wr_en=%b state=%0d, want 0 0 0 IDLE", busy, done, wr_en, dbg_state);
    end
    total++;
    if (got_data_q.size() != 100 || got_addr_q[got_addr_q.size()-1] !== ADDR_W'(99)) begin
      bad++; $display("FAIL abort_count: writes=%0d, want 100 ending at addr 99", got_data_q.size());
    end
    repeat (3 * CLK_DIV) @(posedge sys_clk);
    #1;
    total++; if (got_data_q.size() != 100) begin bad++; $display("FAIL abort_quiet: writes=%0d, want 100", got_data_q.size()); end
    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1;
    @(posedge sys_clk); #1;
    arm = 1'b0; abort = 1'b0;
    repeat (2 * CLK_DIV) @(posedge sys_clk);
    #1;
    total++;
    if (busy !== 1'b0 || got_data_q.size() != 100) begin
      bad++; $display("FAIL abort_beats_arm: busy=%b writes=%0d, want 0 100", busy, got_data_q.size());
    end
    v = 8'($urandom);
    clear_got();
    present(v, 1'b1);
    wait_writes(1);
    total++;
    if (got_addr_q[0] !== '0 || got_data_q[0] !== v || busy !== 1'b1) begin
      bad++; $display("FAIL abort_rearm: addr=%0d data=%h busy=%b, want 0 %h 1", got_addr_q[0], got_data_q[0], busy, v);
    end
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    trig_force = 1'b1;
    clear_got();
    present(8'($urandom), 1'b1);
    wait_writes(500);
    #4 rst_n = 1'b0;
    #1;
    total++; if (adc_clk !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL midrst_clk_en: adc_clk=%b wr_en=%b, want 0 0", adc_clk, wr_en); end
    total++; if (wr_addr !== '0 || wr_data !== 8'h00) begin bad++; $display("FAIL midrst_port: addr=%0d data=%h, want 0 00", wr_addr, wr_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_flags: busy=%b done=%b, want 0 0", busy, done); end
    repeat (3) @(posedge sys_clk);
    #5 rst_n = 1'b1;
    clear_got();
    for (int i = 0; i < 10; i++) present(8'($urandom), 1'b0);
    total++;
    if (got_data_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_no_writes: writes=%0d busy=%b done=%b, want 0 0 0", got_data_q.size(), busy, done);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_force = 1'b0;
    trig_rise = 1'b1; trig_level = 8'h80; adc_data = 8'h00;
    repeat (2) @(posedge sys_clk);
    test_reset();
    test_clocking();
    test_rising();
    test_falling();
    test_force();
    test_abort();
    test_reset_mid();
    finish_run();
  end

endmodule
